// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with a global-stall valid/ready pipe.
// The prefix network is a sequence of T = 2*(NLAYER-1) in-place steps on a
// {P0, G, P, c0} state. Step 0 folds c0 into bit 0. Steps 1..L run the up-sweep.
// The remaining steps run the down-sweep. After the last step, G[i] is the carry out of bit i.
// The steps are split over STAGES registers, and earlier stages take the extra steps.
module bk_adder_pipe #(
  parameter  int NLAYER = 5,
  parameter  int STAGES = 2,
  localparam int W      = 2 ** (NLAYER - 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] inp_a,
  input  logic [W-1:0] inp_b,
  input  logic         inp_carry,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out,
  output logic         ovf
);

  localparam int L    = NLAYER - 1;
  localparam int T    = 2 * L;
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

  if (NLAYER < 2) begin : g_bad_nlayer
    $error("bk_adder_pipe: NLAYER must be >= 2");
  end
  if (STAGES < 1 || STAGES > NLAYER) begin : g_bad_stages
    $error("bk_adder_pipe: STAGES must be in 1..NLAYER");
  end

  typedef struct packed {
    logic [W-1:0] p0;  // bitwise propagate, kept for the final sum
    logic [W-1:0] g;   // running group generate
    logic [W-1:0] p;   // running group propagate
    logic         c0;  // effective carry-in
  } st_t;

  // First step index owned by stage s. Earlier stages absorb the remainder.
  function automatic int bnd(input int s);
    return s * (T / STAGES) + ((s < (T % STAGES)) ? s : (T % STAGES));
  endfunction

  // One prefix level applied in place. Within a level, no written slot is read by another slot.
  function automatic st_t bk_step(input st_t s, input int j);
    st_t r;
    int  d;
    r = s;
    if (j == 0) begin
      r.g[0] = s.g[0] | (s.p[0] & s.c0);
    end else if (j <= L) begin
      d = 1 << (j - 1);
      for (int i = 0; i < W; i++)
        if ((i % (2 * d)) == (2 * d - 1)) begin
          r.g[i] = s.g[i] | (s.p[i] & s.g[i-d]);
          r.p[i] = s.p[i] & s.p[i-d];
        end
    end else begin
      d = 1 << (T - j - 1);
      for (int i = 0; i < W; i++)
        if (i >= 2 * d && (i % (2 * d)) == (d - 1)) begin
          r.g[i] = s.g[i] | (s.p[i] & s.g[i-d]);
          r.p[i] = s.p[i] & s.p[i-d];
        end
    end
    return r;
  endfunction

  logic              adv;
  logic [STAGES:1]   vld_pipe_q;
  logic [W-1:0]      b_eff;
  st_t               pre;
  st_t               st_q [NREG];
  logic [W:0]        out_q, out_d;
  logic              ovf_q, ovf_d;

  // The whole pipe moves together. Ready depends only on the output side.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES];
  assign out       = out_q;
  assign ovf       = ovf_q;

  // Operand conditioning: subtraction computes A + ~B + 1 and ignores carry-in.
  always_comb begin
    b_eff  = sub ? ~inp_b : inp_b;
    pre.p0 = inp_a ^ b_eff;
    pre.g  = inp_a & b_eff;
    pre.p  = inp_a ^ b_eff;
    pre.c0 = sub | inp_carry;
  end

  // Valid shift register. Bubbles travel as zero slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
    end else if (adv) begin
      for (int s = STAGES; s > 1; s--) vld_pipe_q[s] <= vld_pipe_q[s-1];
      vld_pipe_q[1] <= in_valid;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    st_t  st_in, cur;
    logic vin;

    if (s == 0) begin : g_first
      assign st_in = pre;
      assign vin   = in_valid;
    end else begin : g_next
      assign st_in = st_q[s-1];
      assign vin   = vld_pipe_q[s];
    end

    // This stage's share of prefix levels.
    always_comb begin
      cur = st_in;
      for (int j = 0; j < T; j++)
        if (j >= bnd(s) && j < bnd(s + 1)) cur = bk_step(cur, j);
    end

    if (s < STAGES - 1) begin : g_reg
      // Data loads only for valid slots, so junk operands never enter the pipe.
      always_ff @(posedge clk) begin
        if (rst)             st_q[s] <= '0;
        else if (adv && vin) st_q[s] <= cur;
      end
    end else begin : g_out
      // Sum and flags. c[i] = G[i-1], c[0] = c0. Overflow = carry into MSB ^ cout.
      always_comb begin
        out_d = {cur.g[W-1], cur.p0 ^ {cur.g[W-2:0], cur.c0}};
        ovf_d = cur.g[W-1] ^ cur.g[W-2];
      end

      // Output register. It holds its value through stalls and bubbles.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
          ovf_q <= 1'b0;
        end else if (adv && vin) begin
          out_q <= out_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

endmodule
